cnu_ctrl: RTL and testbench
===========================

CNU_CTRL -- requirements
Module: cnu_ctrl

Interface
REQ-001 SHALL have parameter data_w, default 8, magnitude width of tree results.
REQ-002 SHALL have parameter idx_w, default 8, width of the row-global minimum index.
REQ-003 SHALL have parameter D, default 5, messages per beat (comparator tree width).
REQ-004 SHALL have parameter MAX_BEATS, default 4, maximum beats per check row; MAX_BEATS*D <= 2**idx_w.
REQ-005 SHALL have parameter BETA, default 1, offset subtracted when CNU_CTRL_OFFSET_EN is defined.
REQ-006 clk  input  1  single clock; all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 s_valid  input  1  upstream beat of D messages presented to the tree.
REQ-009 s_last  input  1  final beat of the current row, qualified by s_valid.
REQ-010 s_ready  output  1  controller accepts a beat.
REQ-011 tree_en  output  1  enable to comparator tree, equals s_valid & s_ready.
REQ-012 tree_min, tree_min2  input  data_w each  tree result, valid the cycle after tree_en.
REQ-013 tree_idx  input  idx_w  beat-local index (0..D-1) of tree_min.
REQ-014 out_valid  output  1  row result available.
REQ-015 out_ready  input  1  downstream accepts result.
REQ-016 out_min, out_min2  output  data_w each  row smallest and second-smallest magnitude.
REQ-017 out_idx  output  idx_w  row-global index of out_min.
REQ-018 out_err  output  1  row exceeded MAX_BEATS beats.

Function
REQ-019 States SHALL be IDLE, RUN, DRAIN, HOLD.
REQ-020 IDLE: s_ready=1; accepted beat -> RUN, or -> DRAIN if s_last.
REQ-021 RUN: s_ready=1; accepted beat with s_last -> DRAIN; back-to-back beats every cycle allowed.
REQ-022 DRAIN: s_ready=0 for exactly one cycle while the last tree result merges -> HOLD.
REQ-023 HOLD: out_valid=1, outputs stable until out_valid&out_ready -> IDLE; s_ready=0 throughout, rising the cycle after handshake.
REQ-024 A beat counter SHALL record beat number b at accept; the cycle after accept the result SHALL merge with global index b*D+tree_idx.
REQ-025 First beat of a row SHALL load accumulators directly: acc_min=tree_min, acc_min2=tree_min2.
REQ-026 Later merges: acc_min=min(acc_min,tree_min); acc_min2=second smallest of {acc_min,acc_min2,tree_min,tree_min2}.
REQ-027 Ties SHALL keep the accumulated value and index (replace only on strictly smaller).
REQ-028 Latency: out_valid SHALL assert 2 cycles after the s_last accept edge.
REQ-029 Beat MAX_BEATS+1 and later SHALL be accepted and discarded (no merge), counter saturates, out_err=1 for that row.
REQ-030 out_err SHALL clear on the HOLD->IDLE handshake.
REQ-031 s_valid without s_ready SHALL have no effect; s_last only sampled when accepted.

Reset
REQ-032 rst low SHALL immediately force IDLE, beat counter 0, accumulators 0.
REQ-033 Outputs during reset: s_ready=0, tree_en=0, out_valid=0, out_min=0, out_min2=0, out_idx=0, out_err=0; s_ready=1 first cycle after release.
REQ-034 Reset mid-row or in HOLD SHALL discard the partial/pending result without output.

Configuration
REQ-035 Macro CNU_CTRL_OFFSET_EN defined: out_min and out_min2 SHALL be value-BETA saturated at 0 (offset min-sum); out_idx unaffected.
REQ-036 Macro undefined: out_min/out_min2 SHALL equal raw accumulators; BETA unused.

Verification
REQ-037 Single beat, s_last=1, tree gives (3,7,idx 2) -> out (3,7,2) two cycles later, out_err=0.
REQ-038 Three back-to-back beats, results (9,12,1),(4,10,0),(5,6,3) -> out_min=4, out_min2=5, out_idx=5.
REQ-039 Tie: beats (4,8,1),(4,6,2) -> out_min=4, out_idx=1, out_min2=4.
REQ-040 Five beats with MAX_BEATS=4, fifth has tree_min=0 -> result from first four only, out_err=1, clears after handshake.
REQ-041 out_ready low 10 cycles in HOLD -> outputs stable, s_ready=0; raise -> IDLE, s_ready=1 next cycle.
REQ-042 With CNU_CTRL_OFFSET_EN, BETA=1, result (0,2) -> out (0,1); rst low in RUN -> out_valid never asserted for that row.

Source files
------------

// File: rtl/cnu_ctrl.sv
// Row controller for a min-sum check-node unit: merges per-beat comparator-tree results into
// row min / second-min / global index. Optional offset min-sum output via CNU_CTRL_OFFSET_EN.
module cnu_ctrl #(
  parameter int data_w    = 8,
  parameter int idx_w     = 8,
  parameter int D         = 5,
  parameter int MAX_BEATS = 4,
  parameter int BETA      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic              s_last,
  output logic              s_ready,
  output logic              tree_en,
  input  logic [data_w-1:0] tree_min,
  input  logic [data_w-1:0] tree_min2,
  input  logic [idx_w-1:0]  tree_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [data_w-1:0] out_min,
  output logic [data_w-1:0] out_min2,
  output logic [idx_w-1:0]  out_idx,
  output logic              out_err,
  output logic [1:0]        fsm_state
);

  localparam int CNT_W = (MAX_BEATS < 1) ? 1 : $clog2(MAX_BEATS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BEATS);
  localparam logic [idx_w-1:0] D_I = idx_w'(D);

  if (MAX_BEATS * D > 2 ** idx_w) begin : g_bad_idx_w
    $error("cnu_ctrl: MAX_BEATS*D does not fit in idx_w bits");
  end
  if (BETA < 0) begin : g_bad_beta
    $error("cnu_ctrl: BETA must be non-negative");
  end

  // Handshake: a beat transfers on a rising edge where s_valid && s_ready; a result
  // transfers on a rising edge where out_valid && out_ready. Payloads hold while valid.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   beat_cnt;
  logic               mrg_pend;
  logic               mrg_first;
  logic               mrg_drop;
  logic [CNT_W-1:0]   mrg_beat;
  logic [data_w-1:0]  acc_min;
  logic [data_w-1:0]  acc_min2;
  logic [idx_w-1:0]   acc_idx;
  logic               row_err;

  logic               accept;
  logic               beat_over;
  logic [idx_w-1:0]   glb_idx;
  logic [data_w-1:0]  nxt_min;
  logic [data_w-1:0]  nxt_min2;
  logic [idx_w-1:0]   nxt_idx;

  assign accept    = s_valid & s_ready;
  assign tree_en   = accept;
  assign beat_over = (beat_cnt == CNT_MAX);
  assign fsm_state = state_q;

  function automatic logic [data_w-1:0] offset(input logic [data_w-1:0] v);
`ifdef CNU_CTRL_OFFSET_EN
    offset = (v > data_w'(BETA)) ? v - data_w'(BETA) : '0;
`else
    offset = v;
`endif
  endfunction

  // Tree pairs arrive ordered (tree_min <= tree_min2), so the second smallest of the four
  // candidates reduces to one comparison per branch. Equal values keep the accumulated entry.
  always_comb begin
    nxt_min  = acc_min;
    nxt_min2 = acc_min2;
    nxt_idx  = acc_idx;
    glb_idx  = idx_w'(mrg_beat) * D_I + tree_idx;
    if (mrg_pend && !mrg_drop) begin
      if (mrg_first) begin
        nxt_min  = tree_min;
        nxt_min2 = tree_min2;
        nxt_idx  = glb_idx;
      end else if (tree_min < acc_min) begin
        nxt_min  = tree_min;
        nxt_idx  = glb_idx;
        nxt_min2 = (acc_min < tree_min2) ? acc_min : tree_min2;
      end else begin
        nxt_min2 = (tree_min < acc_min2) ? tree_min : acc_min2;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      beat_cnt  <= '0;
      mrg_pend  <= 1'b0;
      mrg_first <= 1'b0;
      mrg_drop  <= 1'b0;
      mrg_beat  <= '0;
      acc_min   <= '0;
      acc_min2  <= '0;
      acc_idx   <= '0;
      row_err   <= 1'b0;
      s_ready   <= 1'b0;
      out_valid <= 1'b0;
      out_min   <= '0;
      out_min2  <= '0;
      out_idx   <= '0;
      out_err   <= 1'b0;
    end else begin
      mrg_pend  <= accept;
      mrg_first <= accept && (beat_cnt == '0);
      mrg_drop  <= accept && beat_over;
      mrg_beat  <= beat_cnt;
      acc_min   <= nxt_min;
      acc_min2  <= nxt_min2;
      acc_idx   <= nxt_idx;

      // Beats past MAX_BEATS are swallowed; the counter parks at MAX_BEATS and flags the row.
      if (accept && !beat_over) beat_cnt <= beat_cnt + 1'b1;
      if (accept && beat_over)  row_err  <= 1'b1;

      case (state_q)
        IDLE, RUN: begin
          s_ready <= !(accept && s_last);
          if (accept) state_q <= s_last ? DRAIN : RUN;
        end
        DRAIN: begin
          state_q   <= HOLD;
          out_valid <= 1'b1;
          out_min   <= offset(nxt_min);
          out_min2  <= offset(nxt_min2);
          out_idx   <= nxt_idx;
          out_err   <= row_err;
        end
        HOLD: begin
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            s_ready   <= 1'b1;
            beat_cnt  <= '0;
            row_err   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnu_ctrl.sv
// Self-checking bench for cnu_ctrl: directed rows, a few random rows, reset cases.
// A row-level model predicts each result; one compare process checks every cycle.
module tb_cnu_ctrl;
  localparam int DW = 8;
  localparam int IW = 8;
  localparam int D = 5;
  localparam int MAXB = 4;
  localparam int BETA = 1;
  localparam int EXP_W = 25;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last = 1'b0;
  logic          s_ready;
  logic          tree_en;
  logic [DW-1:0] tree_min = '0;
  logic [DW-1:0] tree_min2 = '0;
  logic [IW-1:0] tree_idx = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_min;
  logic [DW-1:0] out_min2;
  logic [IW-1:0] out_idx;
  logic          out_err;
  logic [1:0]    fsm_state;

  cnu_ctrl #(.data_w(DW), .idx_w(IW), .D(D), .MAX_BEATS(MAXB), .BETA(BETA)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .tree_en(tree_en), .tree_min(tree_min), .tree_min2(tree_min2), .tree_idx(tree_idx),
    .out_valid(out_valid), .out_ready(out_ready), .out_min(out_min), .out_min2(out_min2),
    .out_idx(out_idx), .out_err(out_err), .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_tests = 0;
  int n_fail = 0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] last_out = '0;
  int rm[8];
  int rm2[8];
  int ri[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ofs(input int v);
`ifdef CNU_CTRL_OFFSET_EN
    return (v > BETA) ? v - BETA : 0;
`else
    return v;
`endif
  endfunction

  // Row model: smallest and second smallest over every value of the kept beats; index of the
  // earliest beat whose tree_min is the row minimum.
  function automatic logic [EXP_W-1:0] model_row(input int n);
    int mn, mn2, idx, used, v;
    logic [7:0] a, b, c;
    logic e;
    mn = 1000; mn2 = 1000; idx = 0;
    used = (n > MAXB) ? MAXB : n;
    for (int k = 0; k < 2 * used; k++) begin
      v = (k % 2 == 0) ? rm[k / 2] : rm2[k / 2];
      if (v < mn) begin mn2 = mn; mn = v; end
      else if (v < mn2) mn2 = v;
    end
    for (int k = used - 1; k >= 0; k--)
      if (rm[k] == mn) idx = k * D + ri[k];
    a = 8'(ofs(mn)); b = 8'(ofs(mn2)); c = 8'(idx); e = (n > MAXB);
    return {a, b, c, e};
  endfunction

  task automatic set_beat(input int k, input int m, input int m2, input int i);
    rm[k] = m; rm2[k] = m2; ri[k] = i;
  endtask

  task automatic present(input bit pend, input int k);
    if (pend) begin
      tree_min = 8'(rm[k]); tree_min2 = 8'(rm2[k]); tree_idx = 8'(ri[k]);
    end else begin
      tree_min = 8'($urandom_range(0, 255)); tree_min2 = 8'($urandom_range(0, 255));
      tree_idx = 8'($urandom_range(0, 255));
    end
  endtask

  // driver: beats on negedges; each tree result shown in the cycle after its accept
  task automatic send_row(input int n, input bit gaps, input bit do_last);
    bit pend;
    int pk;
    pend = 0; pk = 0;
    for (int k = 0; k < n; k++) begin
      if (gaps && k > 0 && $urandom_range(0, 1) == 1) begin
        @(negedge clk);
        s_valid = 0; s_last = 0;
        present(pend, pk); pend = 0;
      end
      @(negedge clk);
      present(pend, pk);
      check("s_ready_at_beat", {31'd0, s_ready}, 32'd1);
      s_valid = 1; s_last = do_last && (k == n - 1);
      pend = 1; pk = k;
    end
    @(negedge clk);
    s_valid = 0; s_last = 0;
    present(pend, pk);
    if (do_last) exp_q.push_back(model_row(n));
  endtask

  task automatic finish_row(input int hold);
    int t;
    t = 0;
    while (!out_valid && t < 20) begin @(negedge clk); t++; end
    check("out_valid_wait", {31'd0, out_valid}, 32'd1);
    for (int k = 0; k < hold; k++) begin
      s_valid = 1'($urandom_range(0, 1)); s_last = 1;
      present(0, 0);
      @(negedge clk);
    end
    s_valid = 0; s_last = 0; out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask

  task automatic pin(input string name, input int m, input int m2, input int i, input int e);
    check({name, "_min"}, {24'd0, last_out[24:17]}, 32'(ofs(m)));
    check({name, "_min2"}, {24'd0, last_out[16:9]}, 32'(ofs(m2)));
    check({name, "_idx"}, {24'd0, last_out[8:1]}, 32'(i));
    check({name, "_err"}, {31'd0, last_out[0]}, 32'(e));
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_s_ready"}, {31'd0, s_ready}, 0);
    check({name, "_tree_en"}, {31'd0, tree_en}, 0);
    check({name, "_out_valid"}, {31'd0, out_valid}, 0);
    check({name, "_out_vals"}, {7'd0, out_min, out_min2, out_idx, out_err}, 0);
  endtask

  // scoreboard / compare process
  int acc_due = -10;
  int rdy_due = -10;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        acc_due = -10; rdy_due = -10;
      end else begin
        check("tree_en", {31'd0, tree_en}, {31'd0, s_valid & s_ready});
        if (acc_due == cyc) check("latency_valid", {31'd0, out_valid}, 1);
        if (acc_due == cyc + 1) check("early_valid", {31'd0, out_valid}, 0);
        if (s_valid && s_ready && s_last) acc_due = cyc + 2;
        if (out_valid) begin
          check("s_ready_in_hold", {31'd0, s_ready}, 0);
          if (exp_q.size() == 0) begin
            check("spurious_valid", {31'd0, out_valid}, 0);
          end else begin
            check("out_result", 32'({out_min, out_min2, out_idx, out_err}), 32'(exp_q[0]));
            if (out_ready) begin
              last_out = {out_min, out_min2, out_idx, out_err};
              void'(exp_q.pop_front());
              rdy_due = cyc + 1;
            end
          end
        end
        if (rdy_due == cyc) begin
          check("s_ready_after_hs", {31'd0, s_ready}, 1);
          check("valid_after_hs", {31'd0, out_valid}, 0);
          check("err_after_hs", {31'd0, out_err}, 0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // reset values
    s_valid = 1;
    #12;
    check_reset_outputs("reset");
    s_valid = 0;
    @(negedge clk); #2 rst = 1;
    @(negedge clk); #1;
    check("ready_after_release", {31'd0, s_ready}, 1);

    // single beat
    set_beat(0, 3, 7, 2);
    send_row(1, 0, 1); finish_row(0);
    pin("single", 3, 7, 2, 0);

    // three back-to-back beats
    set_beat(0, 9, 12, 1); set_beat(1, 4, 10, 0); set_beat(2, 5, 6, 3);
    send_row(3, 0, 1); finish_row(1);
    pin("three", 4, 5, 5, 0);

    // tie keeps first
    set_beat(0, 4, 8, 1); set_beat(1, 4, 6, 2);
    send_row(2, 0, 1); finish_row(0);
    pin("tie", 4, 4, 1, 0);

    // overflow beat discarded
    set_beat(0, 6, 9, 0); set_beat(1, 5, 7, 4); set_beat(2, 8, 8, 2);
    set_beat(3, 7, 10, 1); set_beat(4, 0, 1, 3);
    send_row(5, 0, 1); finish_row(2);
    pin("overflow", 5, 6, 9, 1);

    // long hold with out_ready low
    set_beat(0, 2, 3, 4); set_beat(1, 2, 2, 0);
    send_row(2, 1, 1); finish_row(10);
    pin("hold", 2, 2, 4, 0);

    // offset boundary row
    set_beat(0, 0, 2, 0);
    send_row(1, 0, 1); finish_row(0);
    pin("offset", 0, 2, 0, 0);

    // reset in RUN: partial row vanishes
    set_beat(0, 1, 1, 1); set_beat(1, 1, 2, 2);
    send_row(2, 0, 0);
    rst = 0; #1;
    check_reset_outputs("reset_run");
    @(negedge clk); rst = 1;
    repeat (8) @(negedge clk);
    check("no_valid_after_run_reset", {31'd0, out_valid}, 0);

    // reset in HOLD: pending result dropped
    set_beat(0, 11, 13, 3);
    send_row(1, 0, 1);
    repeat (2) @(negedge clk);
    check("hold_reached", {31'd0, out_valid}, 1);
    rst = 0; exp_q.delete(); #1;
    check_reset_outputs("reset_hold");
    @(negedge clk); rst = 1;
    @(negedge clk); #1;
    check("ready_after_hold_reset", {31'd0, s_ready}, 1);

    // row after reset must load fresh accumulators
    set_beat(0, 30, 40, 4); set_beat(1, 35, 36, 1);
    send_row(2, 0, 1); finish_row(0);
    pin("after_reset", 30, 35, 4, 0);

    // random rows
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) begin
        rm[k] = $urandom_range(0, 200);
        rm2[k] = rm[k] + $urandom_range(0, 50);
        ri[k] = $urandom_range(0, D - 1);
      end
      send_row(n, 1, 1); finish_row($urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
